// File: rtl/jesd204b_link_controller_if.sv
// Lane-status inputs and link-status outputs of the JESD204B link controller.
// The master side drives lane events; the slave side is the controller itself.
interface jesd204b_link_controller_if #(
  parameter int unsigned CNT_WIDTH = 8
) ();
  logic                 i_sysref_done;
  logic                 i_lmfc_edge;
  logic                 i_k_det;
  logic                 i_a_det;
  logic                 i_char_err;
  logic                 i_resync_req;
  logic                 o_sync_n;
  logic                 o_data_valid;
  logic [2:0]           o_state;
  logic [CNT_WIDTH-1:0] o_err_cnt;
  logic                 o_ilas_err;

  modport master (
    output i_sysref_done, i_lmfc_edge, i_k_det, i_a_det, i_char_err, i_resync_req,
    input  o_sync_n, o_data_valid, o_state, o_err_cnt, o_ilas_err
  );

  modport slave (
    input  i_sysref_done, i_lmfc_edge, i_k_det, i_a_det, i_char_err, i_resync_req,
    output o_sync_n, o_data_valid, o_state, o_err_cnt, o_ilas_err
  );
endinterface

// File: rtl/jesd204b_link_controller.sv
// JESD204B receive link controller: CGS, SYNC~ release on LMFC, ILAS checking,
// DATA with error-threshold resync. All outputs are registered.
module jesd204b_link_controller #(
  parameter int unsigned CGS_K_CNT  = 4,
  parameter int unsigned ILAS_MF    = 4,
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                      dclk,
  input  logic                      rst_n,
  jesd204b_link_controller_if.slave lnk
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CGS       = 3'd1,
    ST_SYNC_WAIT = 3'd2,
    ST_ILAS      = 3'd3,
    ST_DATA      = 3'd4
  } state_e;

  localparam logic [7:0]           K_LAST      = 8'(CGS_K_CNT - 1);
  localparam logic [7:0]           MF_LAST     = 8'(ILAS_MF - 1);
  localparam logic [7:0]           ERR_LAST    = 8'(ERR_THRESH - 1);
  localparam logic [CNT_WIDTH-1:0] ERR_CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] ERR_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Internal counters stop at their maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e               state_q, state_d, fsm_next_s;
  logic [7:0]           k_cnt_q, k_cnt_d, k_cnt_s;
  logic [7:0]           mf_cnt_q, mf_cnt_d, mf_cnt_s;
  logic [7:0]           run_err_q, run_err_d, run_err_s;
  logic                 a_seen_q, a_seen_d, a_seen_s;
  logic                 sysref_seen_q, sysref_seen_d;
  logic                 ilas_err_q, ilas_err_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 sync_n_q, sync_n_d;
  logic                 data_valid_q, data_valid_d;
  logic                 resync_s;
  logic                 enter_cgs_s;

  // Next-state, counter and output computation.
  always_comb begin
    fsm_next_s = state_q;
    k_cnt_s    = k_cnt_q;
    mf_cnt_s   = mf_cnt_q;
    a_seen_s   = a_seen_q;
    run_err_s  = run_err_q;
    ilas_err_d = ilas_err_q;

    case (state_q)
      ST_IDLE: begin
        if (sysref_seen_q || lnk.i_sysref_done) fsm_next_s = ST_CGS;
        else                                    fsm_next_s = ST_IDLE;
      end
      ST_CGS: begin
        if (lnk.i_k_det && !lnk.i_char_err) begin
          k_cnt_s = sat_inc8(k_cnt_q);
          if (k_cnt_q == K_LAST) fsm_next_s = ST_SYNC_WAIT;
          else                   fsm_next_s = ST_CGS;
        end else begin
          k_cnt_s = 8'd0;
        end
      end
      ST_SYNC_WAIT: begin
        // A character error outranks the LMFC edge: sync is not trusted.
        if (lnk.i_char_err)       fsm_next_s = ST_CGS;
        else if (lnk.i_lmfc_edge) fsm_next_s = ST_ILAS;
        else                      fsm_next_s = ST_SYNC_WAIT;
      end
      ST_ILAS: begin
        if (lnk.i_lmfc_edge) begin
          a_seen_s = 1'b0;
          if (!(a_seen_q || lnk.i_a_det)) begin
            ilas_err_d = 1'b1;
            fsm_next_s = ST_CGS;
          end else if (mf_cnt_q == MF_LAST) begin
            fsm_next_s = ST_DATA;
          end else begin
            mf_cnt_s = sat_inc8(mf_cnt_q);
          end
        end else begin
          a_seen_s = a_seen_q | lnk.i_a_det;
        end
      end
      ST_DATA: begin
        if (lnk.i_char_err) begin
          run_err_s = sat_inc8(run_err_q);
          if (run_err_q == ERR_LAST) fsm_next_s = ST_CGS;
          else                       fsm_next_s = ST_DATA;
        end else begin
          run_err_s = run_err_q;
        end
      end
      default: fsm_next_s = ST_IDLE;
    endcase

    resync_s    = lnk.i_resync_req && (state_q != ST_IDLE);
    state_d     = resync_s ? ST_CGS : fsm_next_s;
    enter_cgs_s = (state_d == ST_CGS) && ((state_q != ST_CGS) || resync_s);

    k_cnt_d   = enter_cgs_s ? 8'd0 : k_cnt_s;
    mf_cnt_d  = enter_cgs_s ? 8'd0 : mf_cnt_s;
    a_seen_d  = enter_cgs_s ? 1'b0 : a_seen_s;
    run_err_d = enter_cgs_s ? 8'd0 : run_err_s;

    sysref_seen_d = sysref_seen_q | lnk.i_sysref_done;

    if ((state_q != ST_IDLE) && lnk.i_char_err && (err_cnt_q != ERR_CNT_MAX))
      err_cnt_d = err_cnt_q + ERR_CNT_ONE;
    else
      err_cnt_d = err_cnt_q;

    sync_n_d     = (state_d == ST_ILAS) || (state_d == ST_DATA);
    data_valid_d = (state_d == ST_DATA);
  end

  // State, counter and output registers.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      k_cnt_q       <= 8'd0;
      mf_cnt_q      <= 8'd0;
      run_err_q     <= 8'd0;
      a_seen_q      <= 1'b0;
      sysref_seen_q <= 1'b0;
      ilas_err_q    <= 1'b0;
      err_cnt_q     <= {CNT_WIDTH{1'b0}};
      sync_n_q      <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_cnt_q       <= k_cnt_d;
      mf_cnt_q      <= mf_cnt_d;
      run_err_q     <= run_err_d;
      a_seen_q      <= a_seen_d;
      sysref_seen_q <= sysref_seen_d;
      ilas_err_q    <= ilas_err_d;
      err_cnt_q     <= err_cnt_d;
      sync_n_q      <= sync_n_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign lnk.o_state      = state_q;
  assign lnk.o_sync_n     = sync_n_q;
  assign lnk.o_data_valid = data_valid_q;
  assign lnk.o_err_cnt    = err_cnt_q;
  assign lnk.o_ilas_err   = ilas_err_q;

endmodule
